// File: rtl/ibex_wb_rf_arbiter.sv
// ibex_wb_rf_arbiter: merges execute results and in-order load responses onto the register file write port
module ibex_wb_rf_arbiter #(
    parameter int DataWidth = 32,
    parameter int LoadDepth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ex_valid_i,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    output logic                 ex_ready_o,
    input  logic                 lsu_issue_i,
    input  logic [4:0]           lsu_issue_waddr_i,
    output logic                 lsu_issue_ready_o,
    input  logic                 lsu_rvalid_i,
    input  logic [DataWidth-1:0] lsu_rdata_i,
    input  logic                 lsu_err_i,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    output logic                 hazard_a_o,
    output logic                 hazard_b_o,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 load_err_o,
    output logic                 resp_unexp_o
);
    localparam int AW = $clog2(LoadDepth);
    localparam logic [AW:0] Full = (AW+1)'(LoadDepth);

    logic [4:0]           q_addr_q [LoadDepth];
    logic [4:0]           q_addr_d [LoadDepth];
    logic [AW-1:0]        rptr_q, rptr_d, wptr_q, wptr_d;
    logic [AW:0]          cnt_q, cnt_d;
    logic                 we_q, we_d, err_q, err_d, unexp_q, unexp_d;
    logic [4:0]           waddr_q, waddr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic                 push, pop, load_wr, ex_acc, pend_a, pend_b;
    logic [4:0]           head;

    assign ex_ready_o        = !lsu_rvalid_i;
    assign lsu_issue_ready_o = cnt_q != Full;
    assign rf_we_o           = we_q;
    assign rf_waddr_o        = waddr_q;
    assign rf_wdata_o        = wdata_q;
    assign load_err_o        = err_q;
    assign resp_unexp_o      = unexp_q;

    // Next-state: queue pointers, load-priority write selection, error flags
    always_comb begin
        push     = lsu_issue_i && lsu_issue_ready_o;
        pop      = lsu_rvalid_i && cnt_q != '0;
        head     = q_addr_q[rptr_q];
        load_wr  = pop && !lsu_err_i && head != 5'd0;
        ex_acc   = ex_valid_i && ex_ready_o;
        q_addr_d = q_addr_q;
        if (push) q_addr_d[wptr_q] = lsu_issue_waddr_i;
        wptr_d   = wptr_q + AW'(push);
        rptr_d   = rptr_q + AW'(pop);
        cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        we_d     = pop ? load_wr : ex_acc && ex_waddr_i != 5'd0;
        waddr_d  = load_wr ? head : ex_acc ? ex_waddr_i : waddr_q;
        wdata_d  = load_wr ? lsu_rdata_i : ex_acc ? ex_wdata_i : wdata_q;
        err_d    = pop && lsu_err_i;
        unexp_d  = unexp_q || (lsu_rvalid_i && cnt_q == '0);
    end

    // Hazard: read address matches a live queue entry or the write in flight
    always_comb begin
        pend_a = 1'b0;
        pend_b = 1'b0;
        for (int i = 0; i < LoadDepth; i++) begin
            if ({1'b0, AW'(AW'(i) - rptr_q)} < cnt_q) begin
                if (q_addr_q[i] == raddr_a_i) pend_a = 1'b1;
                if (q_addr_q[i] == raddr_b_i) pend_b = 1'b1;
            end
        end
        hazard_a_o = raddr_a_i != 5'd0 && (pend_a || (we_q && waddr_q == raddr_a_i));
        hazard_b_o = raddr_b_i != 5'd0 && (pend_b || (we_q && waddr_q == raddr_b_i));
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_addr_q <= '{default: '0};
            rptr_q   <= '0;
            wptr_q   <= '0;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            unexp_q  <= 1'b0;
        end else begin
            q_addr_q <= q_addr_d;
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            unexp_q  <= unexp_d;
        end
    end
endmodule

// File: tb/tb_ibex_wb_rf_arbiter.sv
// tb_ibex_wb_rf_arbiter: scoreboard bench with a queue-based reference model
module tb_ibex_wb_rf_arbiter;
    localparam int DEP = 2;

    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        ex_valid_i = 0, lsu_issue_i = 0, lsu_rvalid_i = 0, lsu_err_i = 0;
    logic [4:0]  ex_waddr_i = 0, lsu_issue_waddr_i = 0, raddr_a_i = 0, raddr_b_i = 0;
    logic [31:0] ex_wdata_i = 0, lsu_rdata_i = 0;
    logic        ex_ready_o, lsu_issue_ready_o, hazard_a_o, hazard_b_o;
    logic        rf_we_o, load_err_o, resp_unexp_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;

    ibex_wb_rf_arbiter #(.DataWidth(32), .LoadDepth(DEP)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i), .ex_ready_o(ex_ready_o),
        .lsu_issue_i(lsu_issue_i), .lsu_issue_waddr_i(lsu_issue_waddr_i), .lsu_issue_ready_o(lsu_issue_ready_o),
        .lsu_rvalid_i(lsu_rvalid_i), .lsu_rdata_i(lsu_rdata_i), .lsu_err_i(lsu_err_i),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .hazard_a_o(hazard_a_o), .hazard_b_o(hazard_b_o),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .load_err_o(load_err_o), .resp_unexp_o(resp_unexp_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {logic [4:0] a; logic [31:0] d;} wr_t;
    wr_t        exp_q[$];
    logic [4:0] pend[$];
    bit         m_we, m_err, m_unexp, mon_en;
    logic [4:0] m_addr;
    int         tests = 0, fails = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", n, act, req);
        end
    endtask

    function automatic bit hz(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (m_we && m_addr == r) return 1'b1;
        foreach (pend[i]) if (pend[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: in-order pending destinations, load responses win over execute
    initial forever begin
        @(posedge clk_i);
        if (rst_i) begin
            pend.delete();
            exp_q.delete();
            m_we = 0; m_err = 0; m_unexp = 0; m_addr = 0;
        end else begin
            int n;
            logic [4:0] h;
            n = pend.size();
            m_we = 0;
            m_err = 0;
            if (lsu_rvalid_i && n == 0) m_unexp = 1;
            else if (lsu_rvalid_i) begin
                h = pend.pop_front();
                if (lsu_err_i) m_err = 1;
                else if (h != 0) begin
                    m_we = 1; m_addr = h;
                    exp_q.push_back('{h, lsu_rdata_i});
                end
            end else if (ex_valid_i && ex_waddr_i != 0) begin
                m_we = 1; m_addr = ex_waddr_i;
                exp_q.push_back('{ex_waddr_i, ex_wdata_i});
            end
            if (lsu_issue_i && n != DEP) pend.push_back(lsu_issue_waddr_i);
        end
    end

    // Monitor: compare DUT outputs against the model mid-cycle
    initial forever begin
        @(negedge clk_i);
        if (mon_en) begin
            chk("rf_we", rf_we_o, m_we);
            if (m_we && exp_q.size() != 0) begin
                wr_t w;
                w = exp_q.pop_front();
                chk("rf_waddr", rf_waddr_o, w.a);
                chk("rf_wdata", rf_wdata_o, w.d);
            end
            chk("ex_ready", ex_ready_o, !lsu_rvalid_i);
            chk("issue_ready", lsu_issue_ready_o, pend.size() != DEP);
            chk("hazard_a", hazard_a_o, hz(raddr_a_i));
            chk("hazard_b", hazard_b_o, hz(raddr_b_i));
            chk("load_err", load_err_o, m_err);
            chk("resp_unexp", resp_unexp_o, m_unexp);
        end
    end

    task automatic step(input logic ev, input logic [4:0] ew, input logic [31:0] ed,
                        input logic iss, input logic [4:0] iw,
                        input logic rv, input logic [31:0] rd, input logic er,
                        input logic [4:0] ra, input logic [4:0] rb);
        ex_valid_i = ev; ex_waddr_i = ew; ex_wdata_i = ed;
        lsu_issue_i = iss; lsu_issue_waddr_i = iw;
        lsu_rvalid_i = rv; lsu_rdata_i = rd; lsu_err_i = er;
        raddr_a_i = ra; raddr_b_i = rb;
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [4:0] pick_reg();
        logic [4:0] regs [5] = '{5'd0, 5'd3, 5'd5, 5'd7, 5'd9};
        return regs[$urandom_range(0, 4)];
    endfunction

    initial begin
        @(posedge clk_i);
        #1;
        mon_en = 1;
        chk("reset_waddr", rf_waddr_o, 5'd0);
        chk("reset_wdata", rf_wdata_o, 32'd0);
        chk("reset_issue_ready", lsu_issue_ready_o, 1'b1);
        rst_i = 0;
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        chk("ex_write_addr", rf_waddr_o, 5'd5);
        chk("ex_write_data", rf_wdata_o, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        step(0, 0, 0, 1, 3, 0, 0, 0, 3, 7);
        step(0, 0, 0, 1, 7, 0, 0, 0, 3, 7);
        step(0, 0, 0, 0, 0, 1, 32'h11, 0, 3, 7);
        step(0, 0, 0, 0, 0, 1, 32'h22, 0, 3, 7);
        step(0, 0, 0, 0, 0, 0, 0, 0, 3, 7);
        step(0, 0, 0, 0, 0, 0, 0, 0, 3, 7);
        step(0, 0, 0, 1, 1, 0, 0, 0, 1, 2);
        step(0, 0, 0, 1, 2, 0, 0, 0, 1, 2);
        chk("full_not_ready", lsu_issue_ready_o, 1'b0);
        step(0, 0, 0, 1, 4, 1, 32'h33, 0, 2, 4);
        chk("after_refuse_ready", lsu_issue_ready_o, 1'b1);
        step(0, 0, 0, 0, 0, 1, 32'h44, 0, 2, 4);
        step(0, 0, 0, 1, 6, 0, 0, 0, 6, 8);
        step(1, 8, 32'hAA, 0, 0, 1, 32'h55, 0, 6, 8);
        step(1, 8, 32'hAA, 0, 0, 0, 0, 0, 6, 8);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 9);
        step(0, 0, 0, 1, 9, 0, 0, 0, 0, 9);
        step(0, 0, 0, 0, 0, 1, 32'h66, 0, 0, 9);
        step(0, 0, 0, 0, 0, 1, 32'h77, 1, 0, 9);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
        step(0, 0, 0, 0, 0, 1, 32'h88, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 3, 32'h99, 0, 0, 0, 0, 0, 3, 0);
        rst_i = 1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_i = 0;
        for (int i = 0; i < 3000; i++) begin
            rst_i = $urandom_range(0, 149) == 0;
            step($urandom_range(0, 1), pick_reg(), $urandom,
                 $urandom_range(0, 1), pick_reg(),
                 $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 5) == 0,
                 pick_reg(), pick_reg());
        end
        rst_i = 0;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
